autoconfig_seq: RTL and testbench

AUTOCONFIG_SEQ -- requirements
Module: autoconfig_seq

---
 rtl/autoconfig_pkg.sv | 18 +
 rtl/autoconfig_rom.sv | 17 +
 rtl/autoconfig_seq.sv | 110 +++++++++++
 tb/tb_autoconfig_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/autoconfig_pkg.sv
// autoconfig_pkg: shared state encoding, register indices and ROM tables for autoconfig_seq.
package autoconfig_pkg;

    typedef enum logic [1:0] {CFG_RAM, CFG_IDE, DONE} state_e;

    localparam logic [5:0] IDX_BASE_HI = 6'd36;
    localparam logic [5:0] IDX_BASE_LO = 6'd37;
    localparam logic [5:0] IDX_SHUTUP  = 6'd38;

    // Raw nibbles, index 0 in the low nibble: RAM is Zorro II 4MB memlist ($E,$7), IDE is Zorro II 64KB ($C,$1)
    localparam logic [127:0] RAM_ROM = 128'h00000000_00000000_0000BD70_0000017E;
    localparam logic [127:0] IDE_ROM = 128'h00000000_00000000_0000BD70_0000201C;

    function automatic logic [3:0] rom_nibble(input logic [127:0] t, input logic [4:0] i);
        return t[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/autoconfig_rom.sv
// autoconfig_rom: board ROM lookup; indices 0-1 raw, 2-31 inverted, 32-63 read as zero.
module autoconfig_rom
    import autoconfig_pkg::*;
(
    input  logic       ide,
    input  logic [5:0] idx,
    output logic [3:0] nib
);

    logic [3:0] raw;

    always_comb begin
        raw = rom_nibble(ide ? IDE_ROM : RAM_ROM, idx[4:0]);
        nib = idx[5] ? 4'h0 : (idx[4:1] == 4'd0) ? raw : ~raw;
    end

endmodule

// File: rtl/autoconfig_seq.sv
// autoconfig_seq: Zorro II autoconfig chain sequencer, RAM board then IDE board (IDE stage enabled by IDE_AUTOCONFIG_EN).
module autoconfig_seq
    import autoconfig_pkg::*;
(
    input  logic         CLK,
    input  logic         _RESET,
    input  logic         _AS,
    input  logic         R_W,
    input  logic         _UDS,
    input  logic [23:16] AH,
    input  logic [6:1]   AL,
    input  logic [15:12] D_IN,
    output logic [15:12] D_OUT,
    output logic         D_OE,
    output logic         DTACK_RANGE,
    input  logic         _CONFIGIN,
    output logic         _CONFIGOUT,
    output logic         RAM_CFG,
    output logic [23:20] RAM_BASE,
    output logic         IDE_CFG,
    output logic [23:16] IDE_BASE
);

    state_e     state_q, state_d, nxt;
    logic       ram_cfg_q, ram_cfg_d, ide_cfg_q, ide_cfg_d;
    logic [3:0] ram_base_q, ram_base_d, lo_q, lo_d;
    logic [7:0] ide_base_q, ide_base_d;
    logic       seen_q, seen_d, cfgout_n_q, cfgout_n_d;
    logic       sel, wr, cap, is_ide;
    logic [3:0] nib;

    autoconfig_rom u_rom (
        .ide (is_ide),
        .idx (AL),
        .nib (nib)
    );

    always_comb begin
        is_ide      = state_q == CFG_IDE;
        sel         = (AH == 8'hE8) && !_CONFIGIN && (state_q != DONE);
        wr          = sel && !_AS && !_UDS && !R_W;
        cap         = wr && !seen_q;
        DTACK_RANGE = sel;
        D_OE        = sel && R_W && !_UDS;
        D_OUT       = nib;
`ifdef IDE_AUTOCONFIG_EN
        nxt         = (state_q == CFG_RAM) ? CFG_IDE : DONE;
`else
        nxt         = DONE;
`endif
    end

    always_comb begin
        state_d    = state_q;
        ram_cfg_d  = ram_cfg_q;
        ram_base_d = ram_base_q;
        ide_cfg_d  = ide_cfg_q;
        ide_base_d = ide_base_q;
        lo_d       = lo_q;
        // one capture per bus cycle: the flag clears only once _AS goes high
        seen_d     = !_AS && (seen_q || wr);
        if (cap) begin
            if (AL == IDX_BASE_LO) lo_d = D_IN;
            if (AL == IDX_SHUTUP) state_d = nxt;
            if (AL == IDX_BASE_HI) begin
                state_d = nxt;
                if (state_q == CFG_RAM) begin
                    ram_base_d = D_IN;
                    ram_cfg_d  = 1'b1;
                end
`ifdef IDE_AUTOCONFIG_EN
                if (state_q == CFG_IDE) begin
                    ide_base_d = {D_IN, lo_q};
                    ide_cfg_d  = 1'b1;
                end
`endif
            end
        end
        cfgout_n_d = state_d != DONE;
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q    <= CFG_RAM;
            ram_cfg_q  <= 1'b0;
            ram_base_q <= 4'h0;
            ide_cfg_q  <= 1'b0;
            ide_base_q <= 8'h00;
            lo_q       <= 4'h0;
            seen_q     <= 1'b0;
            cfgout_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ram_cfg_q  <= ram_cfg_d;
            ram_base_q <= ram_base_d;
            ide_cfg_q  <= ide_cfg_d;
            ide_base_q <= ide_base_d;
            lo_q       <= lo_d;
            seen_q     <= seen_d;
            cfgout_n_q <= cfgout_n_d;
        end
    end

    assign _CONFIGOUT = cfgout_n_q;
    assign RAM_CFG    = ram_cfg_q;
    assign RAM_BASE   = ram_base_q;
    assign IDE_CFG    = ide_cfg_q;
    assign IDE_BASE   = ide_base_q;

endmodule

// File: tb/tb_autoconfig_seq.sv
// tb_autoconfig_seq: scoreboard bench for autoconfig_seq; follows IDE_AUTOCONFIG_EN for the expected sequence.
module tb_autoconfig_seq;

    localparam logic [20:0] M_BUS = 21'h1F8000;
    localparam logic [20:0] M_SEL = 21'h180000;
    localparam logic [20:0] M_CFG = 21'h007FFF;
`ifdef IDE_AUTOCONFIG_EN
    localparam logic IDE_EN = 1'b1;
`else
    localparam logic IDE_EN = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         _RESET, _AS, R_W, _UDS, _CONFIGIN;
    logic [23:16] AH;
    logic [6:1]   AL;
    logic [15:12] D_IN;
    logic [15:12] D_OUT;
    logic         D_OE, DTACK_RANGE, _CONFIGOUT, RAM_CFG, IDE_CFG;
    logic [23:20] RAM_BASE;
    logic [23:16] IDE_BASE;

    typedef struct {
        string       name;
        logic [20:0] exp;
        logic [20:0] mask;
    } chk_t;

    chk_t       sb[$];
    chk_t       cur;
    int         checks = 0;
    int         errors = 0;
    logic       e_co, e_rc, e_ic;
    logic [3:0] e_rb;
    logic [7:0] e_ib;

    autoconfig_seq dut (
        .CLK         (CLK),
        ._RESET      (_RESET),
        ._AS         (_AS),
        .R_W         (R_W),
        ._UDS        (_UDS),
        .AH          (AH),
        .AL          (AL),
        .D_IN        (D_IN),
        .D_OUT       (D_OUT),
        .D_OE        (D_OE),
        .DTACK_RANGE (DTACK_RANGE),
        ._CONFIGIN   (_CONFIGIN),
        ._CONFIGOUT  (_CONFIGOUT),
        .RAM_CFG     (RAM_CFG),
        .RAM_BASE    (RAM_BASE),
        .IDE_CFG     (IDE_CFG),
        .IDE_BASE    (IDE_BASE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [20:0] snap();
        return {DTACK_RANGE, D_OE, D_OUT, _CONFIGOUT, RAM_CFG, RAM_BASE, IDE_CFG, IDE_BASE};
    endfunction

    always @(negedge CLK) begin
        while (sb.size() != 0) begin
            cur = sb.pop_front();
            checks++;
            if ((snap() & cur.mask) !== (cur.exp & cur.mask)) begin
                errors++;
                $display("FAIL %s got %h want %h", cur.name, snap() & cur.mask, cur.exp & cur.mask);
            end
        end
    end

    task automatic push(input string n, input logic [20:0] e, input logic [20:0] m);
        chk_t c;
        c.name = n;
        c.exp  = e;
        c.mask = m;
        sb.push_back(c);
    endtask

    task automatic exp_cfg(input string n);
        push(n, {6'b0, e_co, e_rc, e_rb, e_ic, e_ib}, M_CFG);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        _AS  = 1'b1;
        _UDS = 1'b1;
        R_W  = 1'b1;
        AH   = 8'h00;
        AL   = 6'd0;
        D_IN = 4'h0;
    endtask

    task automatic model_reset();
        e_co = 1'b1;
        e_rc = 1'b0;
        e_ic = 1'b0;
        e_rb = 4'h0;
        e_ib = 8'h00;
    endtask

    task automatic rd(input string n, input logic [5:0] i, input logic uds, input logic dt,
                      input logic oe, input logic [3:0] d, input logic [20:0] m);
        AH   = 8'hE8;
        AL   = i;
        R_W  = 1'b1;
        _AS  = 1'b0;
        _UDS = uds;
        push(n, {dt, oe, d, 15'b0}, m);
        cyc();
        idle();
        cyc();
    endtask

    task automatic wr(input logic [5:0] i, input logic [3:0] d, input int n);
        AH   = 8'hE8;
        AL   = i;
        D_IN = d;
        R_W  = 1'b0;
        _AS  = 1'b0;
        _UDS = 1'b0;
        repeat (n) cyc();
        idle();
        cyc();
    endtask

    task automatic do_reset();
        _RESET = 1'b0;
        model_reset();
        cyc();
        cyc();
        _RESET = 1'b1;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        _CONFIGIN = 1'b0;
        do_reset();
        exp_cfg("reset_cfg");
        push("reset_bus", 21'h0, M_SEL);
        cyc();

        rd("rd_idx0", 6'd0, 1'b0, 1'b1, 1'b1, 4'hE, M_BUS);
        rd("rd_idx1", 6'd1, 1'b0, 1'b1, 1'b1, 4'h7, M_BUS);
        rd("rd_idx2_inv", 6'd2, 1'b0, 1'b1, 1'b1, 4'hE, M_BUS);
        rd("rd_idx3_inv", 6'd3, 1'b0, 1'b1, 1'b1, 4'hF, M_BUS);
        rd("rd_idx10_inv", 6'd10, 1'b0, 1'b1, 1'b1, 4'h2, M_BUS);
        rd("rd_idx31_inv", 6'd31, 1'b0, 1'b1, 1'b1, 4'hF, M_BUS);
        rd("rd_idx32_zero", 6'd32, 1'b0, 1'b1, 1'b1, 4'h0, M_BUS);
        rd("rd_idx40_zero", 6'd40, 1'b0, 1'b1, 1'b1, 4'h0, M_BUS);
        rd("rd_uds_high", 6'd0, 1'b1, 1'b1, 1'b0, 4'h0, M_SEL);

        _CONFIGIN = 1'b1;
        rd("cfgin_high_rd", 6'd0, 1'b0, 1'b0, 1'b0, 4'h0, M_SEL);
        wr(6'd36, 4'h3, 1);
        exp_cfg("cfgin_high_wr");
        cyc();
        _CONFIGIN = 1'b0;

        wr(6'd10, 4'h5, 1);
        exp_cfg("other_idx_ignored");
        cyc();
        wr(6'd37, 4'h2, 1);
        exp_cfg("lo_write_no_adv");
        cyc();
        wr(6'd36, 4'h2, 5);
        e_rc = 1'b1;
        e_rb = 4'h2;
        e_co = IDE_EN;
        exp_cfg("ram_commit");
        cyc();
`ifdef IDE_AUTOCONFIG_EN
        rd("ide_idx0", 6'd0, 1'b0, 1'b1, 1'b1, 4'hC, M_BUS);
        rd("ide_idx1", 6'd1, 1'b0, 1'b1, 1'b1, 4'h1, M_BUS);
        rd("ide_idx3_inv", 6'd3, 1'b0, 1'b1, 1'b1, 4'hD, M_BUS);
        wr(6'd37, 4'hE, 1);
        wr(6'd36, 4'h9, 1);
        e_ic = 1'b1;
        e_ib = 8'h9E;
        e_co = 1'b0;
        exp_cfg("ide_commit");
        cyc();
`endif
        rd("done_no_sel", 6'd0, 1'b0, 1'b0, 1'b0, 4'h0, M_SEL);

        do_reset();
        wr(6'd38, 4'h5, 1);
        e_co = IDE_EN;
        exp_cfg("shutup_ram");
        cyc();
`ifdef IDE_AUTOCONFIG_EN
        rd("shutup_to_ide", 6'd0, 1'b0, 1'b1, 1'b1, 4'hC, M_BUS);
`else
        rd("shutup_to_done", 6'd0, 1'b0, 1'b0, 1'b0, 4'h0, M_SEL);
`endif

        do_reset();
        wr(6'd37, 4'h3, 1);
        wr(6'd36, 4'h7, 1);
        e_rc = 1'b1;
        e_rb = 4'h7;
        e_co = IDE_EN;
        exp_cfg("pre_async_reset");
        cyc();
        _RESET = 1'b0;
        model_reset();
        exp_cfg("async_reset");
        cyc();
        _RESET = 1'b1;
        cyc();
        rd("restart_ram", 6'd0, 1'b0, 1'b1, 1'b1, 4'hE, M_BUS);

        repeat (4) cyc();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
